fifo_reader: RTL
================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter DW, default 8: FIFO and output data width.
REQ-002 SHALL have parameter CNT_W, default 16: transfer counter width.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1: permits issuing new FIFO reads.
REQ-006 SHALL have port empty, input, 1: FIFO empty flag.
REQ-007 SHALL have port rd_data, input, DW: FIFO read data, valid exactly one cycle after pop.
REQ-008 SHALL have port pop, output, 1: FIFO read request.
REQ-009 SHALL have port m_data, output, DW: downstream data, head of internal buffer.
REQ-010 SHALL have port m_valid, output, 1: m_data holds a valid word.
REQ-011 SHALL have port m_ready, input, 1: downstream accepts the word.
REQ-012 SHALL have port xfer_cnt, output, CNT_W: count of completed downstream transfers.

Function
REQ-013 SHALL hold an internal two-entry in-order buffer; occupancy is tracked by FSM states RD_EMPTY, RD_ONE and RD_TWO.
REQ-014 SHALL keep an inflight flag, set the cycle after pop=1 and clear otherwise.
REQ-015 SHALL define a transfer as m_valid=1 and m_ready=1 in the same cycle.
REQ-016 SHALL drive pop=1 combinationally iff enable=1, empty=0, and (occupancy + inflight - transfer) < 2.
REQ-017 SHALL capture rd_data into the buffer tail in the cycle inflight=1; the read latency is 1.
REQ-018 SHALL drive m_valid=1 iff the state is not RD_EMPTY, and SHALL drive m_data from the oldest entry.
REQ-019 SHALL apply FSM transitions as follows: capture without transfer moves up one state; transfer without capture moves down one state; capture with transfer keeps the state and advances the head.
REQ-020 SHALL never overflow the buffer; a capture in RD_TWO without a transfer is unreachable, and the bench shall assert this.
REQ-021 SHALL hold m_data stable while m_valid=1 and m_ready=0.
REQ-022 SHALL sustain one word per cycle when empty=0, enable=1 and m_ready=1 continuously.
REQ-023 SHALL increment xfer_cnt by 1 per transfer, wrapping modulo 2^CNT_W.
REQ-024 SHALL stop issuing pops when enable=0 while still capturing any inflight word and still draining buffered words.
REQ-025 SHALL ignore rd_data in any cycle where inflight=0.

Reset
REQ-026 SHALL, while rst=1, set state RD_EMPTY, inflight=0, pop=0, m_valid=0, m_data=0 and xfer_cnt=0.
REQ-027 SHALL, when reset occurs mid-operation, discard buffered and inflight words, and SHALL not capture rd_data in the cycle after reset.
REQ-028 SHALL drive pop=0 in every cycle where rst=1, regardless of other inputs.

Structure
REQ-029 SHALL define the enum READER_STATE_e {RD_EMPTY, RD_ONE, RD_TWO} in fifo_pkg.
REQ-030 SHALL define the default DW and CNT_W constants in fifo_pkg.
REQ-031 SHALL reuse the TRUE/FALSE constants from global_pkg.
REQ-032 SHALL place buffer storage and head/tail pointers in sub-module reader_buf2, with the FSM and pop logic kept in fifo_reader.

Verification
REQ-033 SHALL cover single word: FIFO holds 0xA5, enable=1, m_ready=1 -> pop at cycle 0, m_valid=1 with m_data=0xA5 at cycle 2, xfer_cnt=1 at cycle 3.
REQ-034 SHALL cover streaming: FIFO holds 0x01..0x10, m_ready=1 -> 16 consecutive transfers in order, 16 pops total, xfer_cnt=16.
REQ-035 SHALL cover backpressure: m_ready=0 for 10 cycles with FIFO non-empty -> exactly 2 pops, state RD_TWO, m_data stable; then m_ready=1 -> order preserved with no loss or duplication.
REQ-036 SHALL cover enable drop: enable deasserted the cycle after a pop -> the inflight word is captured and delivered, with no further pops.
REQ-037 SHALL cover reset mid-stream: rst=1 for 1 cycle while state is RD_TWO and inflight=1 -> next cycle m_valid=0, xfer_cnt=0, and rd_data is not captured.
REQ-038 SHALL cover counter wrap: with CNT_W=4, 17 transfers -> xfer_cnt=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Types and defaults for the FIFO reader: occupancy states and default widths.
package fifo_pkg;
  typedef enum logic [1:0] {
    RD_EMPTY = 2'd0,
    RD_ONE   = 2'd1,
    RD_TWO   = 2'd2
  } READER_STATE_e;

  localparam int DEF_DW    = 8;
  localparam int DEF_CNT_W = 16;

  function automatic logic [1:0] occupancy(input READER_STATE_e s);
    case (s)
      RD_ONE:  return 2'd1;
      RD_TWO:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction
endpackage

// File: rtl/global_pkg.sv
// Project-wide boolean constants shared by every block.
package global_pkg;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
endpackage

// File: rtl/reader_buf2.sv
// Two-entry in-order word buffer; tail written on push, head advanced on adv.
module reader_buf2
  import fifo_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          adv_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] head_o
);
  logic [DW-1:0] mem_q [2];
  logic          head_q, head_d;
  logic          tail_q, tail_d;

  always_comb begin
    head_d = adv_i  ? ~head_q : head_q;
    tail_d = push_i ? ~tail_q : tail_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= 1'b0;
      tail_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Storage carries no reset; validity is owned by the reader FSM.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[tail_q] <= wdata_i;
  end

  assign head_o = mem_q[head_q];
endmodule

// File: rtl/fifo_reader.sv
// Reads a latency-1 FIFO into a two-entry buffer and presents it as a
// valid/ready stream, counting completed downstream transfers.
module fifo_reader
  import global_pkg::*;
  import fifo_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             empty,
  input  logic [DW-1:0]    rd_data,
  output logic             pop,
  output logic [DW-1:0]    m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] xfer_cnt
);
  READER_STATE_e    state_q, state_d;
  logic             inflight_q;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic             capture, xfer;
  logic [2:0]       committed;
  logic [DW-1:0]    head;

  // A word popped last cycle arrives now; reset discards it.
  assign capture   = inflight_q && !rst;
  assign xfer      = m_valid && m_ready;
  assign committed = {1'b0, occupancy(state_q)} + {2'b00, inflight_q};

  reader_buf2 #(.DW(DW)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (capture),
    .adv_i   (xfer),
    .wdata_i (rd_data),
    .head_o  (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RD_EMPTY;
      inflight_q <= FALSE;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= pop;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    xfer_cnt_d = xfer ? xfer_cnt_q + CNT_W'(1) : xfer_cnt_q;
    case ({capture, xfer})
      2'b10: begin
        case (state_q)
          RD_EMPTY: state_d = RD_ONE;
          default:  state_d = RD_TWO;
        endcase
      end
      2'b01: begin
        case (state_q)
          RD_TWO:  state_d = RD_ONE;
          default: state_d = RD_EMPTY;
        endcase
      end
      default: state_d = state_q;
    endcase
  end

  // Pop only when the word can be guaranteed a buffer slot on arrival.
  always_comb begin
    m_valid = (state_q != RD_EMPTY) && !rst;
    m_data  = m_valid ? head : '0;
    pop     = FALSE;
    if (!rst && enable && !empty && (committed < 3'd2 + {2'b00, xfer}))
      pop = TRUE;
  end

  assign xfer_cnt = xfer_cnt_q;
endmodule
